morse_char_player: RTL
======================

MORSE_CHAR_PLAYER -- requirements
Module: morse_char_player

Interface
REQ-001 Parameter MAX_SYMS, default 5: SHALL set the maximum number of symbols per character (legal range 1..8).
REQ-002 Parameter UNIT_CYCLES, default 1: SHALL set the clock cycles per Morse time unit (legal value >=1).
REQ-003 Parameter DOT_UNITS, default 1: SHALL set the dot on-time in units (legal value >=1).
REQ-004 Parameter DASH_UNITS, default 3: SHALL set the dash on-time in units (legal value >=1).
REQ-005 Parameter GAP_UNITS, default 1: SHALL set the LED-off gap between symbols of one character, in units (legal value >=1).
REQ-006 Port clock, input, 1 bit: SHALL be the clock; all state SHALL update on its rising edge.
REQ-007 Port reset, input, 1 bit: SHALL be reset, synchronous, active-high.
REQ-008 Port chr_strt, input, 1 bit: SHALL request playback of one character.
REQ-009 Port chr_syms, input, MAX_SYMS bits: SHALL give the symbols, bit i = symbol i (1 = dash, 0 = dot), bit 0 played first.
REQ-010 Port chr_len, input, $clog2(MAX_SYMS+1) bits: SHALL give the number of symbols to play.
REQ-011 Port busy, output, 1 bit: SHALL be high while a character is in progress.
REQ-012 Port led_drv, output, 1 bit: SHALL drive the LED, 1 = on.
REQ-013 Port sym_done, output, 1 bit: SHALL be a one-cycle pulse at the end of each symbol's on-time.
REQ-014 Port chr_done, output, 1 bit: SHALL be a one-cycle pulse when the character completes.

Function
REQ-015 All outputs SHALL be driven from registers, with no combinational path from any input to any output.
REQ-016 The FSM SHALL have exactly four states: IDLE, ON, GAP and DONE.
REQ-017 In IDLE, chr_strt=1 SHALL be accepted at the clock edge, and chr_syms and chr_len SHALL be captured at that edge.
REQ-018 Changes to chr_syms and chr_len after acceptance SHALL be ignored until the next acceptance.
REQ-019 chr_strt SHALL be ignored while busy=1.
REQ-020 A chr_len value greater than MAX_SYMS SHALL be clamped to MAX_SYMS.
REQ-021 On acceptance with chr_len>0, the FSM SHALL enter ON in the next cycle with led_drv=1 and busy=1.
REQ-022 In ON, led_drv SHALL stay 1 for exactly DOT_UNITS*UNIT_CYCLES cycles for a dot, or DASH_UNITS*UNIT_CYCLES cycles for a dash.
REQ-023 After a non-final symbol, the FSM SHALL enter GAP for exactly GAP_UNITS*UNIT_CYCLES cycles with led_drv=0, then enter ON for the next symbol.
REQ-024 sym_done SHALL pulse in the first cycle of GAP.
REQ-025 After the final symbol, the FSM SHALL enter DONE for one cycle: led_drv=0, sym_done=1, chr_done=1, busy=0; the next state SHALL be IDLE.
REQ-026 The DONE state SHALL also accept chr_strt=1, in which case the next state SHALL be ON (or DONE if the new chr_len=0), giving back-to-back characters with a single-cycle LED-off separation.
REQ-027 On acceptance with chr_len=0, the FSM SHALL enter DONE in the next cycle with sym_done=0 and chr_done=1, and the LED SHALL never light.
REQ-028 The cycle counter SHALL be sized to hold max(DOT_UNITS,DASH_UNITS,GAP_UNITS)*UNIT_CYCLES without overflow.
REQ-029 The symbol index counter SHALL be sized to hold MAX_SYMS, and SHALL never wrap within a character.
REQ-030 The total character duration from acceptance edge to the chr_done cycle SHALL be sum(on-times) + (n-1)*GAP_UNITS*UNIT_CYCLES + 1 cycles, where n = effective chr_len.
REQ-031 When reset and chr_strt are high together, reset SHALL take priority.

Reset
REQ-032 While reset=1 at a clock edge, the next state SHALL be IDLE.
REQ-033 While reset=1 at a clock edge, led_drv, sym_done, chr_done and busy SHALL all be 0 after that edge.
REQ-034 While reset=1 at a clock edge, all counters SHALL be cleared.
REQ-035 Reset asserted mid-character SHALL abort playback, with no sym_done or chr_done pulse produced.
REQ-036 The first chr_strt SHALL be accepted at the first edge with reset=0.

Verification
REQ-037 The bench SHALL cover: UNIT_CYCLES=2, defaults, "A" (chr_syms=2'b10, chr_len=2) accepted at edge 0 -> led_drv=1 in cycles 1-2; sym_done pulse in cycle 3; led_drv=0 in cycles 3-4; led_drv=1 in cycles 5-10; sym_done=1, chr_done=1 and busy=0 in cycle 11.
REQ-038 The bench SHALL cover: chr_len=0 accepted -> chr_done=1 in the next cycle; led_drv never 1; sym_done never 1.
REQ-039 The bench SHALL cover: chr_len=7 with MAX_SYMS=5 -> exactly 5 sym_done pulses, then chr_done.
REQ-040 The bench SHALL cover: chr_strt pulsed while busy=1, and chr_syms changed mid-character -> no effect on the pattern or timing.
REQ-041 The bench SHALL cover: reset asserted during a dash -> all outputs 0 after the next edge; no chr_done; a new character plays correctly afterwards.
REQ-042 The bench SHALL cover: chr_strt held high continuously -> characters play back to back, each separated by exactly one LED-off DONE cycle.

Source files
------------

// File: rtl/morse_char_player.sv
// Morse character player: plays up to MAX_SYMS dots/dashes of one character
// on an LED. It pulses sym_done at the end of each symbol's on-time and
// chr_done when the character completes. All outputs come from registers.
module morse_char_player #(
    parameter int MAX_SYMS    = 5,
    parameter int UNIT_CYCLES = 1,
    parameter int DOT_UNITS   = 1,
    parameter int DASH_UNITS  = 3,
    parameter int GAP_UNITS   = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             chr_strt,
    input  logic [MAX_SYMS-1:0]              chr_syms,
    input  logic [$clog2(MAX_SYMS+1)-1:0]    chr_len,
    output logic                             busy,
    output logic                             led_drv,
    output logic                             sym_done,
    output logic                             chr_done
);

    localparam int LEN_W    = $clog2(MAX_SYMS + 1);
    localparam int DOT_LEN  = DOT_UNITS * UNIT_CYCLES;
    localparam int DASH_LEN = DASH_UNITS * UNIT_CYCLES;
    localparam int GAP_LEN  = GAP_UNITS * UNIT_CYCLES;
    localparam int MAX_ON   = (DOT_LEN > DASH_LEN) ? DOT_LEN : DASH_LEN;
    localparam int MAX_LEN  = (MAX_ON > GAP_LEN) ? MAX_ON : GAP_LEN;
    // The counter is loaded with (length - 1) and counts down to zero.
    // It is sized for the full length, so it never overflows.
    localparam int CNT_W    = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(DOT_LEN - 1);
    localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(DASH_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_SYMS);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, ON, GAP, DONE} state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [LEN_W-1:0]    sym_idx_reg;
    logic [LEN_W-1:0]    len_reg;
    logic [MAX_SYMS-1:0] syms_reg;
    logic                busy_reg;
    logic                led_reg;
    logic                sym_done_reg;
    logic                chr_done_reg;

    logic [LEN_W-1:0]    len_clamped;
    logic [CNT_W-1:0]    first_load;
    logic [CNT_W-1:0]    next_load;
    logic                last_sym;

    // Over-long requests play MAX_SYMS symbols.
    assign len_clamped = (chr_len > LEN_MAX) ? LEN_MAX : chr_len;
    // On-time of the first symbol comes straight from the request inputs.
    assign first_load  = chr_syms[0] ? DASH_LOAD : DOT_LOAD;
    // syms_reg is shifted when leaving ON, so bit 0 is always the upcoming symbol.
    assign next_load   = syms_reg[0] ? DASH_LOAD : DOT_LOAD;
    // sym_idx_reg never exceeds len_reg - 1, so idx + 1 fits in LEN_W bits.
    assign last_sym    = ((sym_idx_reg + LEN_ONE) == len_reg);

    assign busy     = busy_reg;
    assign led_drv  = led_reg;
    assign sym_done = sym_done_reg;
    assign chr_done = chr_done_reg;

    // Player FSM. The outputs are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            sym_idx_reg  <= '0;
            len_reg      <= '0;
            syms_reg     <= '0;
            busy_reg     <= 1'b0;
            led_reg      <= 1'b0;
            sym_done_reg <= 1'b0;
            chr_done_reg <= 1'b0;
        end else begin
            sym_done_reg <= 1'b0;
            chr_done_reg <= 1'b0;
            case (state_reg)
                // DONE accepts a new request like IDLE does. This makes
                // back-to-back characters with a single LED-off cycle.
                IDLE, DONE: begin
                    led_reg  <= 1'b0;
                    busy_reg <= 1'b0;
                    cnt_reg  <= '0;
                    if (chr_strt) begin
                        syms_reg    <= chr_syms;
                        len_reg     <= len_clamped;
                        sym_idx_reg <= '0;
                        if (len_clamped == '0) begin
                            state_reg    <= DONE;
                            chr_done_reg <= 1'b1;
                        end else begin
                            state_reg <= ON;
                            led_reg   <= 1'b1;
                            busy_reg  <= 1'b1;
                            cnt_reg   <= first_load;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                ON: begin
                    if (cnt_reg == '0) begin
                        led_reg      <= 1'b0;
                        sym_done_reg <= 1'b1;
                        if (last_sym) begin
                            state_reg    <= DONE;
                            chr_done_reg <= 1'b1;
                            busy_reg     <= 1'b0;
                        end else begin
                            state_reg   <= GAP;
                            cnt_reg     <= GAP_LOAD;
                            sym_idx_reg <= sym_idx_reg + LEN_ONE;
                            syms_reg    <= syms_reg >> 1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ON;
                        led_reg   <= 1'b1;
                        cnt_reg   <= next_load;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
